// File: rtl/mainfsm_fpu.sv
// mainfsm_fpu
// -----------------------------------------------------------------------------
// Multicycle control FSM with an added multi-cycle FPU execute state.
// It decodes Op/Funct into per-state datapath selects (Moore outputs) and
// produces the unconditioned enables NextPC/RegW/MemW/FPUW/Branch that the
// conditional-logic stage qualifies downstream.
//
// FPU handshake: on entry to FPUEX a one-cycle FPUStart pulse is issued. The
// FSM then waits for FPUDone. A watchdog counter aborts the wait after
// FPU_TIMEOUT cycles, returns to FETCH and sets the sticky FPUErr flag.
//
// Parameters
//   FPU_TIMEOUT : max cycles spent in FPUEX (legal 2..255)
//   CW          : wait counter width, 2**CW must exceed FPU_TIMEOUT
//
// Ports
//   clk, reset         : clock (rising edge), async active-high reset
//   Op[1:0], Funct[5:0]: instruction class and function bits
//   FPUDone            : FPU result valid, sampled in FPUEX
//   IRWrite, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp :
//                        datapath selects
//   NextPC, RegW, MemW, FPUW, Branch : unconditioned enables
//   FPUStart           : one-cycle FPU launch pulse
//   FPUErr             : sticky FPU timeout flag
//   State[3:0]         : current state code (debug)
// -----------------------------------------------------------------------------
module mainfsm_fpu #(
    parameter int FPU_TIMEOUT = 16,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       FPUDone,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       FPUW,
    output logic       Branch,
    output logic       FPUStart,
    output logic       FPUErr,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        FPUEX  = 4'd10,
        FPUWB  = 4'd11
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(FPU_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout;

    // Only the immediate and load/store bits steer the FSM.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    assign timeout = (cnt_q == CNT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, wait counter and sticky error.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = FETCH;
        cnt_d   = '0;        // counter sits at 0 outside FPUEX, so it is clear on entry
        err_d   = err_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FPUEX;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = FETCH;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            FPUEX: begin
                // Completion has priority over the watchdog in the same cycle.
                if (FPUDone) begin
                    state_d = FPUWB;
                end else if (timeout) begin
                    state_d = FETCH;
                    err_d   = 1'b1;
                end else begin
                    state_d = FPUEX;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            FPUWB:  state_d = FETCH;
            default: state_d = FETCH;   // codes 12..15 recover to FETCH
        endcase
    end

    // Moore output decode.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        FPUW      = 1'b0;
        Branch    = 1'b0;
        FPUStart  = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            EXECR: begin
                ALUOp     = 1'b1;
            end
            EXECI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            ALUWB: begin
                RegW      = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            FPUEX: begin
                // The counter is 0 only in the first FPUEX cycle.
                FPUStart  = (cnt_q == '0);
            end
            FPUWB: begin
                ResultSrc = 2'b11;
                FPUW      = 1'b1;
            end
            default: ;
        endcase
    end

    assign FPUErr = err_q;
    assign State  = state_q;

endmodule

// File: tb/tb_mainfsm_fpu.sv
// tb_mainfsm_fpu
// -----------------------------------------------------------------------------
// Directed testbench for mainfsm_fpu: walks load, store, data-processing
// (immediate and register), branch, FPU completion, FPU timeout, FPU
// completion in the last allowed cycle, and asynchronous reset mid-FPUEX.
// Expected outputs per state come from a hand-written table of the decode.
// -----------------------------------------------------------------------------
module tb_mainfsm_fpu;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       FPUDone;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, FPUW, Branch;
    logic       FPUStart, FPUErr;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    int tests = 0;
    int fails = 0;

    mainfsm_fpu #(.FPU_TIMEOUT(16), .CW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .FPUDone  (FPUDone),
        .IRWrite  (IRWrite),
        .AdrSrc   (AdrSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ResultSrc(ResultSrc),
        .ALUOp    (ALUOp),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .FPUW     (FPUW),
        .Branch   (Branch),
        .FPUStart (FPUStart),
        .FPUErr   (FPUErr),
        .State    (State)
    );

    always #5 clk = ~clk;

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, FPUW, Branch}
    logic [13:0] outv;
    assign outv = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC,
                   RegW, MemW, FPUW, Branch};

    function automatic logic [13:0] exp_out(input logic [3:0] st);
        case (st)
            4'd0:  return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 4'b0000};
            4'd1:  return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 4'b0000};
            4'd2:  return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 4'b0000};
            4'd3:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000};
            4'd4:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 4'b1000};
            4'd5:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0100};
            4'd6:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000};
            4'd7:  return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 4'b0000};
            4'd8:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b1000};
            4'd9:  return {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 4'b0001};
            4'd11: return {1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 4'b0010};
            default: return 14'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check state code, the full select/enable vector and FPUStart.
    task automatic step(input string tag, input logic [3:0] st, input logic start);
        check({tag, ".state"}, 16'(State), 16'(st));
        check({tag, ".outs"},  16'(outv),  16'(exp_out(st)));
        check({tag, ".start"}, 16'(FPUStart), 16'(start));
    endtask

    initial begin
        reset   = 1'b1;
        Op      = 2'b00;
        Funct   = 6'b000000;
        FPUDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        step("rst", 4'd0, 1'b0);
        check("rst.err", 16'(FPUErr), 16'd0);

        // Load: 0,1,2,3,4,0
        Op = 2'b01; Funct = 6'b000001;
        tick(); step("ld.dec",   4'd1, 1'b0);
        tick(); step("ld.adr",   4'd2, 1'b0);
        tick(); step("ld.rd",    4'd3, 1'b0);
        tick(); step("ld.wb",    4'd4, 1'b0);
        tick(); step("ld.fetch", 4'd0, 1'b0);

        // Store: 0,1,2,5,0
        Funct = 6'b000000;
        tick(); step("st.dec",   4'd1, 1'b0);
        tick(); step("st.adr",   4'd2, 1'b0);
        tick(); step("st.wr",    4'd5, 1'b0);
        tick(); step("st.fetch", 4'd0, 1'b0);

        // Data-processing immediate: 0,1,7,8,0
        Op = 2'b00; Funct = 6'b100000;
        tick(); step("dpi.dec",   4'd1, 1'b0);
        tick(); step("dpi.exec",  4'd7, 1'b0);
        tick(); step("dpi.wb",    4'd8, 1'b0);
        tick(); step("dpi.fetch", 4'd0, 1'b0);

        // Data-processing register: 0,1,6,8,0
        Funct = 6'b000001;
        tick(); step("dpr.dec",   4'd1, 1'b0);
        tick(); step("dpr.exec",  4'd6, 1'b0);
        tick(); step("dpr.wb",    4'd8, 1'b0);
        tick(); step("dpr.fetch", 4'd0, 1'b0);

        // Branch: 0,1,9,0
        Op = 2'b10; Funct = 6'b000000;
        tick(); step("br.dec",   4'd1, 1'b0);
        tick(); step("br.br",    4'd9, 1'b0);
        tick(); step("br.fetch", 4'd0, 1'b0);

        // FPU op completing in the 3rd FPUEX cycle
        Op = 2'b11;
        tick(); step("fpu.dec", 4'd1, 1'b0);
        tick(); step("fpu.ex1", 4'd10, 1'b1);
        tick(); step("fpu.ex2", 4'd10, 1'b0);
        tick(); step("fpu.ex3", 4'd10, 1'b0);
        FPUDone = 1'b1;
        tick(); step("fpu.wb", 4'd11, 1'b0);
        FPUDone = 1'b0;
        check("fpu.wb.err", 16'(FPUErr), 16'd0);
        tick(); step("fpu.fetch", 4'd0, 1'b0);
        check("fpu.fetch.err", 16'(FPUErr), 16'd0);

        // FPU timeout: exactly 16 FPUEX cycles, then FETCH with FPUErr set
        tick(); step("to.dec", 4'd1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            step($sformatf("to.ex%0d", i), 4'd10, (i == 1));
            check($sformatf("to.ex%0d.err", i), 16'(FPUErr), 16'd0);
        end
        tick(); step("to.fetch", 4'd0, 1'b0);
        check("to.err.set", 16'(FPUErr), 16'd1);

        // FPUErr is sticky across a branch
        Op = 2'b10;
        tick(); step("to.br.dec", 4'd1, 1'b0);
        tick(); step("to.br.br",  4'd9, 1'b0);
        tick(); step("to.br.fetch", 4'd0, 1'b0);
        check("to.err.hold", 16'(FPUErr), 16'd1);

        // FPUDone in the 16th FPUEX cycle wins over the watchdog
        Op = 2'b11;
        tick(); step("last.dec", 4'd1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            step($sformatf("last.ex%0d", i), 4'd10, (i == 1));
        end
        FPUDone = 1'b1;
        tick(); step("last.wb", 4'd11, 1'b0);
        FPUDone = 1'b0;
        tick(); step("last.fetch", 4'd0, 1'b0);
        check("last.err.hold", 16'(FPUErr), 16'd1);

        // Asynchronous reset between edges while in FPUEX
        tick(); step("ar.dec", 4'd1, 1'b0);
        tick(); step("ar.ex1", 4'd10, 1'b1);
        tick(); step("ar.ex2", 4'd10, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("ar.state",  16'(State),   16'd0);
        check("ar.irw",    16'(IRWrite), 16'd1);
        check("ar.npc",    16'(NextPC),  16'd1);
        check("ar.err",    16'(FPUErr),  16'd0);
        check("ar.start",  16'(FPUStart), 16'd0);
        tick(); step("ar.held", 4'd0, 1'b0);
        reset = 1'b0;
        tick(); step("ar.recover", 4'd1, 1'b0);
        tick(); step("ar.recover.ex", 4'd10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
